// File: rtl/efx_gpio_model.sv
// Behavioural model of a configurable FPGA I/O bank: SDR/DDIO output, registered OE, SDR/DDIO input.
// Latency: one launch edge on registered outputs, one capture edge (plus one with resync) on inputs.
// Backpressure: none; the pads sample and drive every edge unconditionally.
module efx_gpio_model #(
    parameter int    BUS_WIDTH  = 1,
    parameter string TYPE       = "OUT",
    parameter int    OUT_REG    = 1,
    parameter int    OUT_DDIO   = 0,
    parameter int    OUT_RESYNC = 0,
    parameter int    OUTCLK_INV = 0,
    parameter int    OE_REG     = 0,
    parameter int    IN_REG     = 0,
    parameter int    IN_DDIO    = 0,
    parameter int    IN_RESYNC  = 0,
    parameter int    INCLK_INV  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] out_HI,
    input  logic [BUS_WIDTH-1:0] out_LO,
    input  logic                 oe,
    output logic [BUS_WIDTH-1:0] in_HI,
    output logic [BUS_WIDTH-1:0] in_LO,
    inout  wire  [BUS_WIDTH-1:0] io
);

    // Unknown TYPE strings fall through to bidirectional behaviour.
    localparam bit IS_OUT = (TYPE == "OUT");
    localparam bit IS_IN  = (TYPE == "IN");
    localparam bit O_DDIO = (OUT_DDIO != 0);
    localparam bit O_REG  = (OUT_REG != 0) || O_DDIO;
    localparam bit O_INV  = (OUTCLK_INV != 0);
    localparam bit I_DDIO = (IN_DDIO != 0);
    localparam bit I_REG  = (IN_REG != 0) || I_DDIO;
    localparam bit I_INV  = (INCLK_INV != 0);

    logic [BUS_WIDTH-1:0] hi_r;
    logic [BUS_WIDTH-1:0] lo_s;
    logic [BUS_WIDTH-1:0] lo_r;
    logic [BUS_WIDTH-1:0] lo_nxt;
    logic                 oe_r;
    logic [BUS_WIDTH-1:0] cap_hi;
    logic [BUS_WIDTH-1:0] cap_lo;
    logic [BUS_WIDTH-1:0] rs_hi;
    logic [BUS_WIDTH-1:0] rs_lo;
    logic [BUS_WIDTH-1:0] drv_val;
    logic                 oe_eff;
    logic                 drv_en;

    assign lo_nxt = (OUT_RESYNC != 0) ? lo_s : out_LO;

    generate
        if (O_INV) begin : g_launch_fall
            always_ff @(negedge clk) begin
                if (!rst_n) begin
                    hi_r <= '0;
                    lo_s <= '0;
                    oe_r <= 1'b0;
                end else begin
                    hi_r <= out_HI;
                    lo_s <= out_LO;
                    oe_r <= oe;
                end
            end
            always_ff @(posedge clk) begin
                if (!rst_n) lo_r <= '0;
                else        lo_r <= lo_nxt;
            end
        end else begin : g_launch_rise
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    hi_r <= '0;
                    lo_s <= '0;
                    oe_r <= 1'b0;
                end else begin
                    hi_r <= out_HI;
                    lo_s <= out_LO;
                    oe_r <= oe;
                end
            end
            always_ff @(negedge clk) begin
                if (!rst_n) lo_r <= '0;
                else        lo_r <= lo_nxt;
            end
        end

        // rs_* re-register the previous C/C' pair so both halves appear together.
        if (I_INV) begin : g_capture_fall
            always_ff @(negedge clk) begin
                if (!rst_n) begin
                    cap_hi <= '0;
                    rs_hi  <= '0;
                    rs_lo  <= '0;
                end else begin
                    cap_hi <= io;
                    rs_hi  <= cap_hi;
                    rs_lo  <= cap_lo;
                end
            end
            always_ff @(posedge clk) begin
                if (!rst_n) cap_lo <= '0;
                else        cap_lo <= io;
            end
        end else begin : g_capture_rise
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cap_hi <= '0;
                    rs_hi  <= '0;
                    rs_lo  <= '0;
                end else begin
                    cap_hi <= io;
                    rs_hi  <= cap_hi;
                    rs_lo  <= cap_lo;
                end
            end
            always_ff @(negedge clk) begin
                if (!rst_n) cap_lo <= '0;
                else        cap_lo <= io;
            end
        end
    endgenerate

    // DDIO selects by clock level so each half is valid for exactly half a period.
    always_comb begin
        drv_val = out_HI;
        if (O_DDIO) begin
            drv_val = (clk ^ O_INV) ? hi_r : lo_r;
        end else if (O_REG) begin
            drv_val = hi_r;
        end
    end

    assign oe_eff = (OE_REG != 0) ? oe_r : oe;

    always_comb begin
        drv_en = oe_eff;
        if (IS_OUT) drv_en = 1'b1;
        if (IS_IN)  drv_en = 1'b0;
    end

    assign io = drv_en ? drv_val : {BUS_WIDTH{1'bz}};

    always_comb begin
        in_HI = '0;
        in_LO = '0;
        if (!IS_OUT) begin
            if (I_DDIO) begin
                in_HI = (IN_RESYNC != 0) ? rs_hi : cap_hi;
                in_LO = (IN_RESYNC != 0) ? rs_lo : cap_lo;
            end else if (I_REG) begin
                in_HI = cap_hi;
            end else begin
                in_HI = io;
            end
        end
    end

endmodule

// File: tb/tb_efx_gpio_model.sv
// Randomized bench for efx_gpio_model: six bank configurations share one stimulus stream.
// Expected pad/input values come from per-cycle histories of what was applied.
module tb_efx_gpio_model;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] out_hi, out_lo, ext_in, ext_c;
    logic       oe;

    wire  [7:0] io_sdr, io_ddo, io_ddr, io_io, io_in, io_cin;
    logic [7:0] ih_sdr, il_sdr, ih_ddo, il_ddo, ih_ddr, il_ddr;
    logic [7:0] ih_io, il_io, ih_in, il_in, ih_cin, il_cin;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign io_in  = ext_in;
    assign io_cin = ext_c;

    efx_gpio_model #(.BUS_WIDTH(8), .TYPE("OUT"), .OUT_REG(1)) u_sdr (
        .clk(clk), .rst_n(rst_n), .out_HI(out_hi), .out_LO(out_lo), .oe(oe),
        .in_HI(ih_sdr), .in_LO(il_sdr), .io(io_sdr));

    efx_gpio_model #(.BUS_WIDTH(8), .TYPE("OUT"), .OUT_DDIO(1), .OUTCLK_INV(1)) u_ddo (
        .clk(clk), .rst_n(rst_n), .out_HI(out_hi), .out_LO(out_lo), .oe(oe),
        .in_HI(ih_ddo), .in_LO(il_ddo), .io(io_ddo));

    efx_gpio_model #(.BUS_WIDTH(8), .TYPE("OUT"), .OUT_DDIO(1), .OUT_RESYNC(1)) u_ddr (
        .clk(clk), .rst_n(rst_n), .out_HI(out_hi), .out_LO(out_lo), .oe(oe),
        .in_HI(ih_ddr), .in_LO(il_ddr), .io(io_ddr));

    efx_gpio_model #(.BUS_WIDTH(8), .TYPE("INOUT"), .OUT_REG(1), .OE_REG(1), .IN_REG(1)) u_io (
        .clk(clk), .rst_n(rst_n), .out_HI(out_hi), .out_LO(out_lo), .oe(oe),
        .in_HI(ih_io), .in_LO(il_io), .io(io_io));

    efx_gpio_model #(.BUS_WIDTH(8), .TYPE("IN"), .IN_DDIO(1), .IN_RESYNC(1)) u_in (
        .clk(clk), .rst_n(rst_n), .out_HI(out_hi), .out_LO(out_lo), .oe(oe),
        .in_HI(ih_in), .in_LO(il_in), .io(io_in));

    efx_gpio_model #(.BUS_WIDTH(8), .TYPE("IN"), .IN_REG(0)) u_cin (
        .clk(clk), .rst_n(rst_n), .out_HI(out_hi), .out_LO(out_lo), .oe(oe),
        .in_HI(ih_cin), .in_LO(il_cin), .io(io_cin));

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Holds reset across several edges with busy inputs; returns 1ns after the last reset posedge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        out_hi = 8'($urandom);
        out_lo = 8'($urandom);
        oe     = 1'b1;
        ext_in = 8'($urandom);
        ext_c  = 8'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_sdr_io",   io_sdr, 8'h00);
        chk("rst_ddo_io",   io_ddo, 8'h00);
        chk("rst_ddr_io",   io_ddr, 8'h00);
        chk("rst_inout_io", io_io,  8'hzz);
        chk("rst_inout_hi", ih_io,  8'h00);
        chk("rst_inout_lo", il_io,  8'h00);
        chk("rst_in_hi",    ih_in,  8'h00);
        chk("rst_in_lo",    il_in,  8'h00);
        @(posedge clk);
        #1;
        chk("rst_ddo_io_hiphase", io_ddo, 8'h00);
        chk("rst_ddr_io_hiphase", io_ddr, 8'h00);
    endtask

    // Each iteration k: checks at P(k)+1, drive at P(k)+2, checks at N(k)+1, next ext at N(k)+2.
    task automatic run(input int n);
        logic [7:0] hi_p   = 8'h00;
        logic [7:0] lo_p   = 8'h00;
        logic [7:0] a_cur  = 8'h00;
        logic [7:0] a_p    = 8'h00;
        logic [7:0] b_p    = 8'h00;
        logic [7:0] e_prev = 8'h00;
        logic [7:0] e_cur  = 8'hzz;
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            chk("sdr_io",      io_sdr, hi_p);
            chk("ddr_io_hi",   io_ddr, hi_p);
            chk("ddo_io_lo",   io_ddo, lo_p);
            chk("in_ddio_hi",  ih_in,  a_p);
            chk("in_ddio_lo",  il_in,  b_p);
            chk("inout_in_hi", ih_io,  e_prev);
            chk("inout_in_lo", il_io,  8'h00);
            chk("out_in_hi",   ih_sdr, 8'h00);
            chk("out_in_lo",   il_sdr, 8'h00);
            #1;
            rst_n  = 1'b1;
            out_hi = 8'($urandom);
            out_lo = 8'($urandom);
            oe     = 1'($urandom_range(0, 1));
            if (k == 0) begin
                out_hi = 8'hff;
                out_lo = 8'h00;
            end
            if (k == 1) oe = 1'b0;
            if (k == 2) begin
                oe     = 1'b1;
                out_hi = 8'h12;
            end
            b      = 8'($urandom);
            ext_in = b;
            ext_c  = 8'($urandom);
            if (k == 3) ext_c = 8'h3c;
            #1;
            chk("comb_in_hi", ih_cin, ext_c);
            chk("comb_in_lo", il_cin, 8'h00);
            @(negedge clk);
            #1;
            chk("sdr_io_hold", io_sdr, hi_p);
            chk("ddo_io_hi",   io_ddo, out_hi);
            chk("ddr_io_lo",   io_ddr, lo_p);
            chk("inout_io",    io_io,  e_cur);
            #1;
            a_p    = a_cur;
            b_p    = b;
            a_cur  = 8'($urandom);
            ext_in = a_cur;
            hi_p   = out_hi;
            lo_p   = out_lo;
            e_prev = e_cur;
            e_cur  = oe ? out_hi : 8'hzz;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        out_hi = 8'h00;
        out_lo = 8'h00;
        oe     = 1'b0;
        ext_in = 8'h00;
        ext_c  = 8'h00;
        do_reset();
        run(40);
        do_reset();
        run(40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/efx_gpio_model.md
# efx_gpio_model

- Behavioural model of one configurable FPGA I/O bank of `BUS_WIDTH` pads.
- Supports output, input and bidirectional use, with optional registering, double-data-rate (DDIO), resync and clock-edge inversion selected by parameters.
- Sits between controller logic and board-level pins: HyperBus CS_N, CK_P/CK_N, RWDS, DQ.
- Lets system simulation reproduce pad-register timing, including DDR capture of read data.

## Interface
Parameters:
- `BUS_WIDTH`, 1: number of pads.
- `TYPE`, "OUT": "OUT", "IN" or "INOUT". Any other value is treated as "INOUT".
- `OUT_REG`, 1: 1 = output path registered, 0 = combinational.
- `OUT_DDIO`, 0: 1 = DDR output. Forces output registering regardless of `OUT_REG`.
- `OUT_RESYNC`, 0: 1 = `out_LO` is captured on the launch edge instead of the second edge.
- `OUTCLK_INV`, 0: 1 = output launch edge is falling.
- `OE_REG`, 0: 1 = `oe` registered.
- `IN_REG`, 0: 1 = input path registered.
- `IN_DDIO`, 0: 1 = DDR input. Forces input registering regardless of `IN_REG`.
- `IN_RESYNC`, 0: 1 = both DDR input halves are re-registered on the capture edge.
- `INCLK_INV`, 0: 1 = input capture edge is falling.

Ports:
- `clk` in 1: the single clock for all registers.
- `rst_n` in 1: reset, synchronous, active-low.
- `out_HI` in BUS_WIDTH: data for the first half-cycle, or SDR data.
- `out_LO` in BUS_WIDTH: data for the second half-cycle (DDIO only).
- `oe` in 1: output enable for the whole bus.
- `in_HI` out BUS_WIDTH: captured pad data, first half.
- `in_LO` out BUS_WIDTH: captured pad data, second half.
- `io` inout BUS_WIDTH: pad.

## Operation
Edge definitions:
- Launch edge (L): rising edge of `clk` if `OUTCLK_INV`=0, otherwise falling edge. The opposite edge is L'.
- Capture edge (C): rising edge of `clk` if `INCLK_INV`=0, otherwise falling edge. The opposite edge is C'.

Output path:
- Combinational (`OUT_REG`=0, `OUT_DDIO`=0): drive value = `out_HI`.
- SDR: `hi_r` ← `out_HI` at L; drive value = `hi_r`.
- DDIO: `hi_r` ← `out_HI` at L.
  - `OUT_RESYNC`=0: `lo_r` ← `out_LO` at L'.
  - `OUT_RESYNC`=1: `lo_s` ← `out_LO` at L, then `lo_r` ← `lo_s` at L'.
  - Drive value = `hi_r` in the half-period after L, `lo_r` in the half-period after L'. Selection is by clock level: `hi_r` while (`clk` XOR `OUTCLK_INV`)=1.
- Effective enable: `oe_r` ← `oe` at L when `OE_REG`=1, otherwise `oe` directly.
- Pad drive by `TYPE`:
  - "OUT": pad always driven.
  - "INOUT": driven when the effective enable is 1, otherwise 'z'.
  - "IN": never driven (all 'z').

Input path (`TYPE` "IN" or "INOUT"; for "OUT", `in_HI` = `in_LO` = 0):
- Combinational: `in_HI` = `io`, `in_LO` = 0.
- SDR: `in_HI` ← `io` at C; `in_LO` = 0.
- DDIO: `cap_hi` ← `io` at C; `cap_lo` ← `io` at C'.
  - `IN_RESYNC`=0: `in_HI` = `cap_hi`, `in_LO` = `cap_lo`.
  - `IN_RESYNC`=1: at the next C, `in_HI` ← `cap_hi` and `in_LO` ← `cap_lo`. The pair captured at C(n) and C'(n) is presented together after C(n+1).
- In input-only use the pad's own driven value is what is sampled; values pass through unmodified, including 'x'/'z'.

Reset:
- While `rst_n`=0, every register clears to 0 on its own active edge (L, L', C or C').
- Consequences after reset: SDR/DDIO pad drives 0; a registered OE gives 'z' on "INOUT"; registered `in_HI`/`in_LO` = 0.
- Combinational paths are unaffected by reset.

## Timing
- SDR output: the pad follows `out_HI` one launch edge after sampling, with zero delta delay after L.
- DDIO output: two values per clock period, each valid for half a period.
- Registered OE: drive and release occur at the L following the `oe` change.
- Input SDR latency: 1 capture edge.
- Input DDIO latency:
  - No resync: `in_HI` at C, `in_LO` at C'.
  - Resync: both at the next C, which is 1 cycle for HI and ½ cycle for LO.
- All bits of the bus behave identically; `oe` is shared by all bits.
- Reset asserted mid-burst: the next active edge clears the corresponding register. No partial-half hold is required.

## Test plan
- SDR out, `OUT_REG`=1, `BUS_WIDTH`=1: `out_HI`=1 before a rising edge → `io`=1 after that edge and held for the whole cycle.
- DDIO clock-style out, `OUTCLK_INV`=1, `out_HI`=1, `out_LO`=0 steady → `io`=1 after each falling edge and 0 after each rising edge.
- INOUT with `OE_REG`=1, `BUS_WIDTH`=8: `oe`=0 → `io`=8'hzz. Raise `oe`=1 with `out_HI`=8'h12 → `io`=8'h12 only after the next L.
- DDIO in with resync, `BUS_WIDTH`=8: external 8'hA5 at C and 8'h5A at C' → after the following C, `in_HI`=8'hA5 and `in_LO`=8'h5A simultaneously.
- Combinational in, `IN_REG`=0: external 8'h3C → `in_HI`=8'h3C with no clock, `in_LO`=0.
- Reset, `OE_REG`=1 and `IN_REG`=1: `rst_n`=0 across one full clock period → `io`='z', `in_HI`=`in_LO`=0. Release `rst_n` → normal operation from the next edge.
